// File: rtl/nrf_spi_xfer_pkg.sv
// Shared types and constants for the nRF24L01+ SPI transaction engine.
// Command opcodes are provided for software-facing code and benches.
package nrf_spi_xfer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCsnSetup,
      StLoad,
      StShift,
      StCsnHold,
      StGap
   } xfer_state_e;

   localparam logic [7:0] CmdRRegister  = 8'h00;
   localparam logic [7:0] CmdWRegister  = 8'h20;
   localparam logic [7:0] CmdRRxPayload = 8'h61;
   localparam logic [7:0] CmdWTxPayload = 8'hA0;
   localparam logic [7:0] CmdFlushTx    = 8'hE1;
   localparam logic [7:0] CmdFlushRx    = 8'hE2;
   localparam logic [7:0] CmdNop        = 8'hFF;

   function automatic logic [5:0] clamp_len(logic [5:0] len, int unsigned max_len);
      if (len > 6'(max_len)) return 6'(max_len);
      return len;
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte: SCK half-period divider, MSB-first TX/RX shift and byte_done pulse.
// Idle between bytes with SCK low; a new byte starts on load_i.
module spi_byte_shifter #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] tx_byte_i,
   input  logic       miso_i,
   output logic       sck_o,
   output logic       mosi_o,
   output logic [7:0] rx_byte_o,
   output logic       byte_done_o
);

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   logic       active_q, active_d;
   logic       sck_q, sck_d;
   logic       done_q, done_d;
   logic [7:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [7:0] rx_q, rx_d;

   always_comb begin
      active_d = active_q;
      sck_d    = sck_q;
      done_d   = 1'b0;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_sh_d  = rx_sh_q;
      rx_d     = rx_q;
      if (load_i) begin
         active_d = 1'b1;
         sck_d    = 1'b0;
         div_d    = 8'd0;
         bit_d    = 3'd0;
         tx_d     = tx_byte_i;
      end else if (active_q) begin
         if (div_q == DivLast) begin
            div_d = 8'd0;
            if (!sck_q) begin
               sck_d   = 1'b1;
               rx_sh_d = {rx_sh_q[6:0], miso_i};
            end else begin
               sck_d = 1'b0;
               if (bit_q == 3'd7) begin
                  // MOSI holds the last bit; the next load replaces it.
                  active_d = 1'b0;
                  done_d   = 1'b1;
                  rx_d     = rx_sh_q;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = {tx_q[6:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         sck_q    <= 1'b0;
         done_q   <= 1'b0;
         div_q    <= 8'd0;
         bit_q    <= 3'd0;
         tx_q     <= 8'd0;
         rx_sh_q  <= 8'd0;
         rx_q     <= 8'd0;
      end else begin
         active_q <= active_d;
         sck_q    <= sck_d;
         done_q   <= done_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_sh_q  <= rx_sh_d;
         rx_q     <= rx_d;
      end
   end

   assign sck_o       = sck_q;
   assign mosi_o      = tx_q[7];
   assign rx_byte_o   = rx_q;
   assign byte_done_o = done_q;

endmodule

// File: rtl/nrf_spi_xfer.sv
// nRF24L01+ SPI transaction engine: CSN-framed multi-byte transfer with TX/RX streaming,
// plus IRQ synchroniser and CE register.
module nrf_spi_xfer
   import nrf_spi_xfer_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned CSN_HIGH_MIN = 4,
   parameter int unsigned MAX_LEN      = 33
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       start,
   input  logic [5:0] len,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   input  logic       ce_in,
   output logic       nrf_ce,
   output logic       nrf_csn,
   output logic       nrf_sck,
   output logic       nrf_mosi,
   input  logic       nrf_miso,
   input  logic       nrf_irq,
   output logic       irq_n_sync
);

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast = 8'(CSN_HIGH_MIN - 1);

   xfer_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  byte_cnt_q, byte_cnt_d;
   logic        csn_q, csn_d;
   logic        done_q, done_d;
   logic        ce_q;
   logic        irq_meta_q, irq_sync_q;
   logic        load;
   logic        byte_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      done_d     = 1'b0;
      tx_ready   = 1'b0;
      load       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && (len != 6'd0)) begin
               len_d      = clamp_len(len, MAX_LEN);
               byte_cnt_d = 6'd0;
               cnt_d      = 8'd0;
               state_d    = StCsnSetup;
            end
         end
         StCsnSetup: begin
            if (cnt_q == DivLast) begin
               cnt_d   = 8'd0;
               state_d = StLoad;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StLoad: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               load    = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (byte_done) begin
               byte_cnt_d = byte_cnt_q + 6'd1;
               if (byte_cnt_d == len_q) begin
                  cnt_d   = 8'd0;
                  state_d = StCsnHold;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StCsnHold: begin
            if (cnt_q == DivLast) begin
               cnt_d   = 8'd0;
               done_d  = 1'b1;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d   = 8'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // CSN is registered from the next state so the pin never sees decode glitches.
      csn_d = (state_d == StIdle) || (state_d == StGap);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         len_q      <= 6'd0;
         byte_cnt_q <= 6'd0;
         csn_q      <= 1'b1;
         done_q     <= 1'b0;
         ce_q       <= 1'b0;
         irq_meta_q <= 1'b1;
         irq_sync_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         csn_q      <= csn_d;
         done_q     <= done_d;
         ce_q       <= ce_in;
         irq_meta_q <= nrf_irq;
         irq_sync_q <= irq_meta_q;
      end
   end

   spi_byte_shifter #(
      .CLK_DIV(CLK_DIV)
   ) u_shifter (
      .clk_i      (clk_clk),
      .rst_ni     (reset_reset_n),
      .load_i     (load),
      .tx_byte_i  (tx_data),
      .miso_i     (nrf_miso),
      .sck_o      (nrf_sck),
      .mosi_o     (nrf_mosi),
      .rx_byte_o  (rx_data),
      .byte_done_o(byte_done)
   );

   assign rx_valid   = byte_done;
   assign busy       = (state_q != StIdle) && (state_q != StGap);
   assign done       = done_q;
   assign nrf_csn    = csn_q;
   assign nrf_ce     = ce_q;
   assign irq_n_sync = irq_sync_q;

endmodule
